mem_port_arbiter: RTL and testbench

//  Shares one memory port between instruction fetch (IF) and data load/store (D)

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// data load/store (D) requesters, one outstanding transaction at a time.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration; when
// undefined, D has fixed priority bounded by a starvation limit for IF.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                  state_q;
  logic                    owner_d_q;   // 1: transaction belongs to D, 0: IF
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    if_pref;     // IF wins a tie this cycle
  logic                    if_win;
  logic                    d_win;
  logic                    idle;

  assign idle = (state_q == IDLE);

`ifdef MEM_ARB_RR_EN
  logic last_d_q;                       // last grant went to D
  assign if_pref = last_d_q;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q;              // consecutive D grants while IF waits
  assign if_pref = (starve_q == CW'(STARVE_LIMIT));
`endif

  // Arbitration: grants are only issued from IDLE and never while in reset
  always_comb begin
    if_win = rst & idle & if_req & (~d_req | if_pref);
    d_win  = rst & idle & d_req & ~if_win;
  end

  // Transaction FSM with latched memory-side request fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q  <= 1'b0;
`else
      starve_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (if_win || d_win) begin
            owner_d_q <= d_win;
            we_q      <= d_win & d_we;
            addr_q    <= d_win ? d_addr : if_addr;
            wdata_q   <= d_win ? d_wdata : '0;
            state_q   <= REQ;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= d_win;
`endif
          end
`ifndef MEM_ARB_RR_EN
          if (d_win && if_req) begin
            if (starve_q != CW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
          end else if (if_win || !if_req) begin
            starve_q <= '0;
          end
`endif
        end
        REQ: begin
          // A store completes on acceptance; a load waits for its data
          if (mem_gnt) state_q <= we_q ? IDLE : RESP;
        end
        RESP: begin
          if (mem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode: grants and read data are combinational, memory side is registered
  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_req   = (state_q == REQ);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rvalid = (state_q == RESP) & mem_rvalid & ~owner_d_q;
    d_rvalid  = (state_q == RESP) & mem_rvalid & owner_d_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
    stall     = rst & (~idle | (if_req & d_req));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, stall;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the single outstanding transaction and arbitration history
  bit            m_busy;      // a transaction has been granted and not finished
  bit            m_acc;       // memory accepted it, waiting for read data
  bit            m_own_d;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_starve;    // D grants in a row that IF sat through
  bit            m_last_d;    // previous grant went to D
  bit            g_if, g_d;   // grants predicted for the current cycle

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_acc = 0; m_own_d = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_starve = 0; m_last_d = 0;
    g_if = 0; g_d = 0;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".if_gnt"},    64'(if_gnt),    64'd0);
    chk({tag, ".d_gnt"},     64'(d_gnt),     64'd0);
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
    chk({tag, ".d_rvalid"},  64'(d_rvalid),  64'd0);
    chk({tag, ".if_rdata"},  64'(if_rdata),  64'd0);
    chk({tag, ".d_rdata"},   64'(d_rdata),   64'd0);
    chk({tag, ".mem_req"},   64'(mem_req),   64'd0);
    chk({tag, ".mem_we"},    64'(mem_we),    64'd0);
    chk({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, ".stall"},     64'(stall),     64'd0);
  endtask

  // Compare every output with the model's prediction for the current inputs
  task automatic sample();
    bit pref, e_ifrv, e_drv;
    #1;
    g_if = 0; g_d = 0;
    if (!m_busy) begin
`ifdef MEM_ARB_RR_EN
      pref = m_last_d;
`else
      pref = (m_starve >= SL);
`endif
      if (if_req && (!d_req || pref)) g_if = 1;
      else if (d_req)                 g_d  = 1;
    end
    e_ifrv = m_busy && m_acc && mem_rvalid && !m_own_d;
    e_drv  = m_busy && m_acc && mem_rvalid && m_own_d;
    chk("if_gnt",    64'(if_gnt),    64'(g_if));
    chk("d_gnt",     64'(d_gnt),     64'(g_d));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_ifrv));
    chk("d_rvalid",  64'(d_rvalid),  64'(e_drv));
    chk("if_rdata",  64'(if_rdata),  e_ifrv ? 64'(mem_rdata) : 64'd0);
    chk("d_rdata",   64'(d_rdata),   e_drv  ? 64'(mem_rdata) : 64'd0);
    chk("mem_req",   64'(mem_req),   64'(m_busy && !m_acc));
    chk("mem_we",    64'(mem_we),    64'(m_we));
    chk("mem_addr",  64'(mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("stall",     64'(stall),     64'(m_busy || (if_req && d_req)));
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic advance();
    if (!m_busy) begin
`ifndef MEM_ARB_RR_EN
      if (g_d && if_req)          m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
      else if (g_if || !if_req)   m_starve = 0;
`endif
      if (g_if || g_d) begin
        m_busy = 1; m_acc = 0; m_own_d = g_d; m_last_d = g_d;
        m_we    = g_d && d_we;
        m_addr  = g_d ? d_addr : if_addr;
        m_wdata = g_d ? d_wdata : '0;
      end
    end else if (!m_acc) begin
      if (mem_gnt) begin
        if (m_we) m_busy = 0;
        else      m_acc  = 1;
      end
    end else if (mem_rvalid) begin
      m_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    m_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  int  gseq[$];
  bit  exp_d;

  initial begin
    rst = 1;
    idle_inputs();
    m_reset();
    @(negedge clk);
    do_reset();

    // 1: single fetch, zero-wait memory
    if_req = 1; if_addr = 32'h10; mem_gnt = 1;
    sample(); chk("t1.if_gnt", 64'(if_gnt), 64'd1); advance();
    if_req = 0; if_addr = '0;
    sample(); chk("t1.mem_req", 64'(mem_req), 64'd1); chk("t1.mem_addr", 64'(mem_addr), 64'h10); advance();
    mem_rvalid = 1; mem_rdata = 32'h00500513;
    sample(); chk("t1.if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t1.if_rdata", 64'(if_rdata), 64'h00500513); advance();
    idle_inputs();
    cycle();

    // 2: tie between fetch and load, D wins first
    if_req = 1; if_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h100; mem_gnt = 1;
    sample(); chk("t2.d_gnt", 64'(d_gnt), 64'd1); chk("t2.stall0", 64'(stall), 64'd1); advance();
    d_req = 0;
    sample(); chk("t2.stall1", 64'(stall), 64'd1); advance();
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    sample(); chk("t2.d_rvalid", 64'(d_rvalid), 64'd1); chk("t2.stall2", 64'(stall), 64'd1); advance();
    mem_rvalid = 0;
    sample(); chk("t2.if_gnt", 64'(if_gnt), 64'd1); advance();
    if_req = 0;
    cycle();
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    cycle();
    idle_inputs();
    cycle();

    // 3: store held off by memory for three cycles
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    sample(); chk("t3.d_gnt", 64'(d_gnt), 64'd1); advance();
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3); mem_rvalid = 1;
      sample();
      chk("t3.mem_req",   64'(mem_req),   64'd1);
      chk("t3.mem_we",    64'(mem_we),    64'd1);
      chk("t3.mem_addr",  64'(mem_addr),  64'h200);
      chk("t3.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      chk("t3.d_rvalid",  64'(d_rvalid),  64'd0);
      advance();
    end
    mem_gnt = 0;
    sample(); chk("t3.idle", 64'(mem_req), 64'd0); chk("t3.d_rvalid_after", 64'(d_rvalid), 64'd0); advance();
    idle_inputs();

    // 4/6: both requesters held continuously
    do_reset();
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
    gseq.delete();
    for (int c = 0; c < 60 && gseq.size() < 10; c++) begin
      sample();
      if (g_if) gseq.push_back(0);
      if (g_d)  gseq.push_back(1);
      advance();
    end
    chk("t4.grant_count", 64'(gseq.size()), 64'd10);
    for (int k = 0; k < gseq.size() && k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = !(k == 4 || k == 9);
`endif
      chk($sformatf("t4.grant%0d_is_d", k), 64'(gseq[k]), 64'(exp_d));
    end
    idle_inputs();
    cycle();

    // 5: reset during RESP, then stray read data
    if_req = 1; if_addr = 32'h24; mem_gnt = 1;
    cycle();
    if_req = 0;
    cycle();
    mem_gnt = 0; mem_rvalid = 0;
    cycle();
    if_req = 1; d_req = 1; mem_rvalid = 1; mem_rdata = 32'h77777777;
    rst = 0;
    #1;
    check_zero("t5");
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    if_req = 0; d_req = 0; mem_rvalid = 1;
    sample(); chk("t5.if_rvalid", 64'(if_rvalid), 64'd0); chk("t5.d_rvalid", 64'(d_rvalid), 64'd0); advance();
    mem_gnt = 1; mem_rvalid = 0;
    sample(); chk("t5.mem_req", 64'(mem_req), 64'd0); advance();
    idle_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (if_req && !g_if) begin
        if ($urandom_range(0, 19) == 0) if_req = 0;
      end else begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end
      if (d_req && !g_d) begin
        if ($urandom_range(0, 19) == 0) d_req = 0;
      end else begin
        d_req   = ($urandom_range(0, 1) == 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_gnt    = $urandom_range(0, 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
